// File: rtl/enc_pkg.sv
// Shared types and constants for the serial priority encoder.
// ENC_MSB_FIRST_EN selects highest-set-bit-first service order.
package enc_pkg;

  typedef enum logic {IDLE, SERVE} state_t;

  function automatic int w_of(input int n);
    return 1 << n;
  endfunction

`ifdef ENC_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

endpackage

// File: rtl/prio_enc_nbits.sv
// Combinational W-to-N priority encoder; direction follows enc_pkg::MSB_FIRST.
// Zero latency, no flow control; o_any flags a non-empty vector.
module prio_enc_nbits
  import enc_pkg::*;
#(
  parameter  int N = 3,
  localparam int W = w_of(N)
) (
  input  logic [W-1:0] i_vec,
  output logic [N-1:0] o_idx,
  output logic         o_any
);

  // The last matching assignment wins, so scan order sets the priority.
  always_comb begin
    o_idx = '0;
    o_any = |i_vec;
    if (MSB_FIRST) begin
      for (int i = 0; i < W; i++) begin
        if (i_vec[i]) o_idx = N'(i);
      end
    end else begin
      for (int i = W - 1; i >= 0; i--) begin
        if (i_vec[i]) o_idx = N'(i);
      end
    end
  end

endmodule

// File: rtl/encoder_nbits_serial.sv
// Serialises a captured 2^N-bit request vector into N-bit indices (ENC_MSB_FIRST_EN: descending).
// First index one cycle after load, one per handshake; o_Y/o_valid hold under backpressure.
module encoder_nbits_serial
  import enc_pkg::*;
#(
  parameter  int N = 3,
  localparam int W = w_of(N)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_A,
  input  logic         i_EN,
  output logic         o_ready,
  output logic [N-1:0] o_Y,
  output logic         o_valid,
  input  logic         i_ready,
  output logic         o_zero
);

  state_t         r_state;
  logic [W-1:0]   r_pend;
  logic [N-1:0]   r_Y;
  logic           r_valid;
  logic           r_zero;

  logic [N-1:0]   w_a_idx;
  logic           w_a_any;
  logic [N-1:0]   w_p_idx;
  logic           w_p_any;
  logic [W-1:0]   w_a_clr;
  logic [W-1:0]   w_p_clr;
  logic           w_hs;

  prio_enc_nbits #(.N(N)) u_cap_enc (
    .i_vec (i_A),
    .o_idx (w_a_idx),
    .o_any (w_a_any)
  );

  prio_enc_nbits #(.N(N)) u_pend_enc (
    .i_vec (r_pend),
    .o_idx (w_p_idx),
    .o_any (w_p_any)
  );

  assign w_a_clr = i_A    & ~(W'(1) << w_a_idx);
  assign w_p_clr = r_pend & ~(W'(1) << w_p_idx);
  assign w_hs    = r_valid & i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_pend  <= '0;
      r_Y     <= '0;
      r_valid <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      r_zero <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_EN) begin
            if (w_a_any) begin
              r_pend  <= w_a_clr;
              r_Y     <= w_a_idx;
              r_valid <= 1'b1;
              r_state <= SERVE;
            end else begin
              r_zero <= 1'b1;
            end
          end
        end
        SERVE: begin
          if (w_hs) begin
            if (w_p_any) begin
              r_Y    <= w_p_idx;
              r_pend <= w_p_clr;
            end else begin
              r_Y     <= '0;
              r_valid <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ready = (r_state == IDLE);
  assign o_Y     = r_Y;
  assign o_valid = r_valid;
  assign o_zero  = r_zero;

endmodule

// File: tb/tb_encoder_nbits_serial.sv
// Directed bench for encoder_nbits_serial (N=3); expectations follow ENC_MSB_FIRST_EN.
module tb_encoder_nbits_serial;

  localparam int N = 3;
  localparam int W = 8;

`ifdef ENC_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif

  logic         i_clk;
  logic         i_rst_n;
  logic [W-1:0] i_A;
  logic         i_EN;
  logic         o_ready;
  logic [N-1:0] o_Y;
  logic         o_valid;
  logic         i_ready;
  logic         o_zero;

  int n_checks = 0;
  int n_errors = 0;

  encoder_nbits_serial #(.N(N)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_A     (i_A),
    .i_EN    (i_EN),
    .o_ready (o_ready),
    .o_Y     (o_Y),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_zero  (o_zero)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Index expected at position j of an ascending LSB-first list, mirrored for MSB-first.
  function automatic int pick(input int lo, input int hi);
    return MSB ? hi : lo;
  endfunction

  initial begin
    int cnt;
    i_rst_n = 1'b1;
    i_A     = '0;
    i_EN    = 1'b0;
    i_ready = 1'b0;

    // Asynchronous reset asserted away from any clock edge
    #3 i_rst_n = 1'b0;
    #1;
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_Y",     int'(o_Y),     0);
    chk("rst_zero",  int'(o_zero),  0);
    chk("rst_ready", int'(o_ready), 1);
    tick();
    tick();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    chk("post_rst_valid", int'(o_valid), 0);
    chk("post_rst_ready", int'(o_ready), 1);
    chk("post_rst_Y",     int'(o_Y),     0);

    // Basic 8'b0010_0100; i_EN stays high with 8'hFF during SERVE and must be ignored
    @(negedge i_clk);
    i_A = 8'b0010_0100; i_EN = 1'b1; i_ready = 1'b1;
    tick();
    i_A = 8'hFF;
    chk("basic_v0",     int'(o_valid), 1);
    chk("basic_y0",     int'(o_Y),     pick(2, 5));
    chk("basic_rdy0",   int'(o_ready), 0);
    tick();
    chk("basic_v1",     int'(o_valid), 1);
    chk("basic_y1",     int'(o_Y),     pick(5, 2));
    tick();
    i_EN = 1'b0; i_A = '0;
    chk("basic_v_end",  int'(o_valid), 0);
    chk("basic_rdy_end", int'(o_ready), 1);
    chk("basic_y_end",  int'(o_Y),     0);
    tick();
    chk("basic_idle_v", int'(o_valid), 0);

    // Backpressure with 8'h81
    @(negedge i_clk);
    i_A = 8'h81; i_EN = 1'b1; i_ready = 1'b0;
    tick();
    i_EN = 1'b0; i_A = '0;
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_v", int'(o_valid), 1);
      chk("bp_hold_y", int'(o_Y),     pick(0, 7));
      tick();
    end
    chk("bp_hold_v3", int'(o_valid), 1);
    chk("bp_hold_y3", int'(o_Y),     pick(0, 7));
    i_ready = 1'b1;
    tick();
    chk("bp_v1", int'(o_valid), 1);
    chk("bp_y1", int'(o_Y),     pick(7, 0));
    tick();
    chk("bp_v_end",   int'(o_valid), 0);
    chk("bp_rdy_end", int'(o_ready), 1);

    // Zero load: one-cycle o_zero pulse, no output
    @(negedge i_clk);
    i_A = 8'h00; i_EN = 1'b1;
    tick();
    i_EN = 1'b0;
    chk("zero_pulse", int'(o_zero),  1);
    chk("zero_valid", int'(o_valid), 0);
    chk("zero_ready", int'(o_ready), 1);
    tick();
    chk("zero_clear", int'(o_zero),  0);
    chk("zero_valid2", int'(o_valid), 0);

    // Single bit set
    @(negedge i_clk);
    i_A = 8'h10; i_EN = 1'b1;
    tick();
    i_EN = 1'b0; i_A = '0;
    chk("single_v", int'(o_valid), 1);
    chk("single_y", int'(o_Y),     4);
    tick();
    chk("single_v_end", int'(o_valid), 0);
    chk("single_rdy",   int'(o_ready), 1);

    // Full vector: 8 indices on consecutive cycles, 9 cycles busy
    @(negedge i_clk);
    i_A = 8'hFF; i_EN = 1'b1;
    tick();
    i_EN = 1'b0; i_A = '0;
    cnt = 1;
    while (!o_ready && cnt < 20) begin
      chk("full_v", int'(o_valid), 1);
      chk("full_y", int'(o_Y),     pick(cnt - 1, 8 - cnt));
      tick();
      cnt++;
    end
    chk("full_cycles", cnt, 9);
    chk("full_v_end",  int'(o_valid), 0);

    // Reset in the middle of serving discards pending bits
    @(negedge i_clk);
    i_A = 8'hFF; i_EN = 1'b1;
    tick();
    i_EN = 1'b0; i_A = '0;
    tick();
    #2 i_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(o_valid), 0);
    chk("mid_rst_ready", int'(o_ready), 1);
    chk("mid_rst_Y",     int'(o_Y),     0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    chk("mid_rel_valid", int'(o_valid), 0);
    tick();
    chk("mid_rel_valid2", int'(o_valid), 0);
    chk("mid_rel_ready",  int'(o_ready), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
